// File: rtl/saturn_pkg.sv
// Shared constants, jump FSM state and offset helpers for the Saturn PC/RSTK unit.
package saturn_pkg;

  localparam int unsigned PH_W  = 4;
  localparam int unsigned PH_0  = 0;
  localparam int unsigned PH_1  = 1;
  localparam int unsigned PH_2  = 2;
  localparam int unsigned PH_3  = 3;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned JL_W  = 3;
  localparam int unsigned K_W   = 3;
  localparam int unsigned OFF_W = 20;

  localparam logic [JL_W-1:0] JL_REL2 = 3'd1;
  localparam logic [JL_W-1:0] JL_REL3 = 3'd2;
  localparam logic [JL_W-1:0] JL_REL4 = 3'd3;
  localparam logic [JL_W-1:0] JL_ABS5 = 3'd4;

  typedef enum logic {
    JS_IDLE   = 1'b0,
    JS_DECODE = 1'b1
  } jump_state_e;

  // Sign-extend an assembled offset of (len+1) nibbles to the full offset width.
  function automatic logic [OFF_W-1:0] sext_offset(input logic [OFF_W-1:0] off,
                                                   input logic [JL_W-1:0]  len);
    case (len)
      JL_REL2: sext_offset = {{12{off[7]}},  off[7:0]};
      JL_REL3: sext_offset = {{8{off[11]}},  off[11:0]};
      JL_REL4: sext_offset = {{4{off[15]}},  off[15:0]};
      default: sext_offset = off;
    endcase
  endfunction

  function automatic logic jl_legal(input logic [JL_W-1:0] len);
    return (len >= JL_REL2) && (len <= JL_ABS5);
  endfunction

endpackage

// File: rtl/saturn_rstk_stack.sv
// Circular-buffer return stack: push discards oldest when full, pop of empty reads 0.
module saturn_rstk_stack
  import saturn_pkg::*;
#(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned RSTK_DEPTH = 8,
  parameter int unsigned CNT_W      = $clog2(RSTK_DEPTH) + 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_push,
  input  logic                          i_pop,
  input  logic [ADDR_W-1:0]             i_push_val,
  input  logic [$clog2(RSTK_DEPTH)-1:0] i_dbg_idx,
  output logic [ADDR_W-1:0]             o_top_val,
  output logic [CNT_W-1:0]              o_count,
  output logic                          o_overflow,
  output logic [ADDR_W-1:0]             o_dbg_val
);

  localparam int unsigned PTR_W = $clog2(RSTK_DEPTH);

  logic [ADDR_W-1:0] mem_q [RSTK_DEPTH];
  logic [ADDR_W-1:0] mem_d [RSTK_DEPTH];
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              empty_c, full_c;
  logic [PTR_W-1:0]  dbg_ptr_c;

  assign empty_c   = (cnt_q == '0);
  assign full_c    = (cnt_q == CNT_W'(RSTK_DEPTH));
  assign dbg_ptr_c = top_q - i_dbg_idx;

  assign o_top_val  = empty_c ? '0 : mem_q[top_q];
  assign o_dbg_val  = (CNT_W'(i_dbg_idx) < cnt_q) ? mem_q[dbg_ptr_c] : '0;
  assign o_count    = cnt_q;
  assign o_overflow = ovf_q;

  // Pop+push on a non-empty stack replaces the top in place.
  always_comb begin
    mem_d = mem_q;
    top_d = top_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (i_push && i_pop && !empty_c) begin
      mem_d[top_q] = i_push_val;
    end else if (i_push) begin
      top_d        = top_q + PTR_W'(1);
      mem_d[top_d] = i_push_val;
      if (full_c) ovf_d = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end else if (i_pop && !empty_c) begin
      top_d = top_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < int'(RSTK_DEPTH); i++) mem_q[i] <= '0;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/saturn_pc_rstk_gen2.sv
// Saturn PC, GOTO/GOSUB target assembly, RTN and RSTK access arbitration.
module saturn_pc_rstk_gen2
  import saturn_pkg::*;
#(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned RSTK_DEPTH = 8,
  parameter int unsigned CNT_W      = $clog2(RSTK_DEPTH) + 1
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_clk_en,
  input  logic [PH_W-1:0]               i_phases,
  input  logic                          i_stall,
  input  logic [NIB_W-1:0]              i_nibble,
  input  logic                          i_jump_instr,
  input  logic [JL_W-1:0]               i_jump_length,
  input  logic                          i_jump_relative,
  input  logic                          i_push_pc,
  input  logic                          i_rtn_instr,
  input  logic                          i_rstk_push,
  input  logic [ADDR_W-1:0]             i_rstk_push_val,
  input  logic                          i_rstk_pop,
  output logic [ADDR_W-1:0]             o_rstk_pop_val,
  output logic [ADDR_W-1:0]             o_current_pc,
  output logic                          o_jump_busy,
  output logic [CNT_W-1:0]              o_rstk_count,
  output logic                          o_rstk_overflow,
  input  logic [$clog2(RSTK_DEPTH)-1:0] i_dbg_rstk_idx,
  output logic [ADDR_W-1:0]             o_dbg_rstk_val
);

  jump_state_e       state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic              just_reset_q, just_reset_d;
  logic              busy_q;

  logic              qual_c, ph1_c, ph2_c, ph3_c;
  logic              jump_done_c, rtn_take_c, gosub_c;
  logic              push_c, pop_c;
  logic [ADDR_W-1:0] push_val_c, top_val_c, jmp_target_c;
  logic [OFF_W-1:0]  off_full_c;
  logic              ph0_unused;

  assign ph0_unused = i_phases[PH_0];
  assign qual_c     = i_clk_en && !i_stall;
  assign ph1_c      = i_phases[PH_1];
  assign ph2_c      = i_phases[PH_2];
  assign ph3_c      = i_phases[PH_3];

  // Offset including the nibble arriving this cycle, so completion needs no extra clock.
  assign off_full_c   = off_q | (OFF_W'(i_nibble) << {k_q, 2'b00});
  assign jmp_target_c = i_jump_relative
                      ? base_q + ADDR_W'($signed(sext_offset(off_full_c, i_jump_length)))
                      : ADDR_W'(off_full_c);

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    pc_d         = pc_q;
    base_d       = base_q;
    off_d        = off_q;
    just_reset_d = just_reset_q;
    jump_done_c  = 1'b0;
    rtn_take_c   = 1'b0;
    gosub_c      = 1'b0;
    push_c       = 1'b0;
    pop_c        = 1'b0;
    push_val_c   = i_rstk_push_val;

    if (qual_c) begin
      if (ph3_c) just_reset_d = 1'b0;
      if (ph1_c && !just_reset_q) pc_d = pc_q + ADDR_W'(1);

      case (state_q)
        JS_IDLE: begin
          if (ph3_c && i_jump_instr && !just_reset_q) begin
            state_d = JS_DECODE;
            base_d  = pc_q;
            k_d     = '0;
            off_d   = '0;
          end
        end
        JS_DECODE: begin
          if (!i_jump_instr) begin
            state_d = JS_IDLE;
          end else if (ph2_c) begin
            if (!jl_legal(i_jump_length)) begin
              state_d = JS_IDLE;
            end else if (k_q == i_jump_length) begin
              jump_done_c = 1'b1;
              pc_d        = jmp_target_c;
              state_d     = JS_IDLE;
            end else begin
              off_d = off_full_c;
              k_d   = k_q + K_W'(1);
            end
          end
        end
        default: state_d = JS_IDLE;
      endcase

      // A completing jump overrides RTN; a GOSUB push overrides RSTK=C / C=RSTK.
      rtn_take_c = ph3_c && i_rtn_instr && !jump_done_c;
      if (rtn_take_c) pc_d = top_val_c;
      gosub_c = jump_done_c && i_push_pc;
      if (gosub_c) begin
        push_c     = 1'b1;
        push_val_c = pc_q;
      end else begin
        push_c = i_rstk_push;
      end
      pop_c = rtn_take_c || (i_rstk_pop && !gosub_c);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= JS_IDLE;
      k_q          <= '0;
      pc_q         <= '0;
      base_q       <= '0;
      off_q        <= '0;
      just_reset_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      pc_q         <= pc_d;
      base_q       <= base_d;
      off_q        <= off_d;
      just_reset_q <= just_reset_d;
      busy_q       <= (state_d == JS_DECODE);
    end
  end

  saturn_rstk_stack #(
    .ADDR_W     (ADDR_W),
    .RSTK_DEPTH (RSTK_DEPTH),
    .CNT_W      (CNT_W)
  ) u_stack (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_push     (push_c),
    .i_pop      (pop_c),
    .i_push_val (push_val_c),
    .i_dbg_idx  (i_dbg_rstk_idx),
    .o_top_val  (top_val_c),
    .o_count    (o_rstk_count),
    .o_overflow (o_rstk_overflow),
    .o_dbg_val  (o_dbg_rstk_val)
  );

  assign o_rstk_pop_val = top_val_c;
  assign o_current_pc   = pc_q;
  assign o_jump_busy    = busy_q;

endmodule

// File: tb/tb_saturn_pc_rstk_gen2.sv
// Directed bench for saturn_pc_rstk_gen2: PC gate, jumps, RSTK rules, stall and reset.
module tb_saturn_pc_rstk_gen2;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = 3;

  logic              i_clk = 1'b0;
  logic              i_reset_n;
  logic              i_clk_en;
  logic [3:0]        i_phases;
  logic              i_stall;
  logic [3:0]        i_nibble;
  logic              i_jump_instr;
  logic [2:0]        i_jump_length;
  logic              i_jump_relative;
  logic              i_push_pc;
  logic              i_rtn_instr;
  logic              i_rstk_push;
  logic [ADDR_W-1:0] i_rstk_push_val;
  logic              i_rstk_pop;
  logic [ADDR_W-1:0] o_rstk_pop_val;
  logic [ADDR_W-1:0] o_current_pc;
  logic              o_jump_busy;
  logic [CNT_W-1:0]  o_rstk_count;
  logic              o_rstk_overflow;
  logic [IDX_W-1:0]  i_dbg_rstk_idx;
  logic [ADDR_W-1:0] o_dbg_rstk_val;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  saturn_pc_rstk_gen2 #(
    .ADDR_W     (ADDR_W),
    .RSTK_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .i_clk           (i_clk),
    .i_reset_n       (i_reset_n),
    .i_clk_en        (i_clk_en),
    .i_phases        (i_phases),
    .i_stall         (i_stall),
    .i_nibble        (i_nibble),
    .i_jump_instr    (i_jump_instr),
    .i_jump_length   (i_jump_length),
    .i_jump_relative (i_jump_relative),
    .i_push_pc       (i_push_pc),
    .i_rtn_instr     (i_rtn_instr),
    .i_rstk_push     (i_rstk_push),
    .i_rstk_push_val (i_rstk_push_val),
    .i_rstk_pop      (i_rstk_pop),
    .o_rstk_pop_val  (o_rstk_pop_val),
    .o_current_pc    (o_current_pc),
    .o_jump_busy     (o_jump_busy),
    .o_rstk_count    (o_rstk_count),
    .o_rstk_overflow (o_rstk_overflow),
    .i_dbg_rstk_idx  (i_dbg_rstk_idx),
    .o_dbg_rstk_val  (o_dbg_rstk_val)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with a single phase asserted; outputs sampled 1 time unit after the edge.
  task automatic ph(input int p);
    i_phases = 4'(1 << p);
    @(posedge i_clk);
    #1;
  endtask

  // Start at phase3, then one phase0/1/2 group per offset nibble (LSB nibble first).
  task automatic jump(input logic rel, input logic push, input logic [2:0] len,
                      input logic [19:0] nibs);
    i_jump_instr    = 1'b1;
    i_jump_relative = rel;
    i_push_pc       = push;
    i_jump_length   = len;
    ph(3);
    chk("busy_enter", 32'(o_jump_busy), 32'h1);
    for (int i = 0; i <= int'(len); i++) begin
      ph(0);
      ph(1);
      i_nibble = nibs[4*i +: 4];
      ph(2);
      if (i < int'(len)) ph(3);
    end
    i_jump_instr    = 1'b0;
    i_push_pc       = 1'b0;
    i_jump_relative = 1'b0;
    chk("busy_done", 32'(o_jump_busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rest;
    i_reset_n = 1'b0; i_clk_en = 1'b1; i_phases = 4'b0001; i_stall = 1'b0;
    i_nibble = '0; i_jump_instr = 1'b0; i_jump_length = 3'd0; i_jump_relative = 1'b0;
    i_push_pc = 1'b0; i_rtn_instr = 1'b0; i_rstk_push = 1'b0; i_rstk_push_val = '0;
    i_rstk_pop = 1'b0; i_dbg_rstk_idx = '0;

    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_pc",    32'(o_current_pc),    32'h0);
    chk("rst_count", 32'(o_rstk_count),    32'h0);
    chk("rst_busy",  32'(o_jump_busy),     32'h0);
    chk("rst_ovf",   32'(o_rstk_overflow), 32'h0);
    chk("rst_pop",   32'(o_rstk_pop_val),  32'h0);
    chk("rst_dbg",   32'(o_dbg_rstk_val),  32'h0);
    i_reset_n = 1'b1;

    // No increment until the first qualified phase3 clears the post-reset gate.
    ph(0); ph(1);
    chk("gate_ph1", 32'(o_current_pc), 32'h0);
    ph(2); ph(3);
    chk("gate_ph3", 32'(o_current_pc), 32'h0);
    repeat (3) begin ph(0); ph(1); ph(2); ph(3); end
    chk("pc_after_3", 32'(o_current_pc), 32'h3);
    chk("count_idle", 32'(o_rstk_count), 32'h0);

    jump(1'b0, 1'b0, 3'd4, 20'h00100);
    chk("abs_00100", 32'(o_current_pc), 32'h00100);
    jump(1'b1, 1'b0, 3'd2, 20'h00FFF);
    chk("rel3_neg", 32'(o_current_pc), 32'h000FF);
    // Entry at 01233 so the first offset nibble is fetched at PC 01234.
    jump(1'b0, 1'b0, 3'd4, 20'h01233);
    chk("abs_01233", 32'(o_current_pc), 32'h01233);
    jump(1'b0, 1'b1, 3'd4, 20'h12345);
    chk("gosub_pc",    32'(o_current_pc),   32'h12345);
    chk("gosub_top",   32'(o_rstk_pop_val), 32'h01238);
    chk("gosub_count", 32'(o_rstk_count),   32'h1);

    i_rstk_pop = 1'b1;
    chk("cpop_val", 32'(o_rstk_pop_val), 32'h01238);
    ph(0);
    i_rstk_pop = 1'b0;
    chk("cpop_count", 32'(o_rstk_count), 32'h0);

    i_rstk_push = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      i_rstk_push_val = 20'(i);
      ph(0);
      chk("push_ovf", 32'(o_rstk_overflow), 32'(i == 9));
    end
    i_rstk_push = 1'b0;
    ph(0);
    chk("ovf_pulse_end", 32'(o_rstk_overflow), 32'h0);
    chk("full_count",    32'(o_rstk_count),    32'h8);
    i_dbg_rstk_idx = 3'd0; #1;
    chk("dbg_top",    32'(o_dbg_rstk_val), 32'h9);
    i_dbg_rstk_idx = 3'd7; #1;
    chk("dbg_bottom", 32'(o_dbg_rstk_val), 32'h2);

    i_rstk_pop = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("pop_seq", 32'(o_rstk_pop_val), (i < 8) ? 32'(9 - i) : 32'h0);
      ph(0);
    end
    i_rstk_pop = 1'b0;
    chk("empty_count", 32'(o_rstk_count), 32'h0);
    chk("dbg_empty",   32'(o_dbg_rstk_val), 32'h0);

    i_rstk_push = 1'b1; i_rstk_push_val = 20'h00777;
    ph(0);
    i_rstk_pop = 1'b1; i_rstk_push_val = 20'h0ABCD;
    chk("pp_old_top", 32'(o_rstk_pop_val), 32'h00777);
    ph(0);
    i_rstk_push = 1'b0; i_rstk_pop = 1'b0;
    chk("pp_new_top", 32'(o_rstk_pop_val),  32'h0ABCD);
    chk("pp_count",   32'(o_rstk_count),    32'h1);
    chk("pp_no_ovf",  32'(o_rstk_overflow), 32'h0);

    i_rtn_instr = 1'b1;
    ph(3);
    chk("rtn_pc",    32'(o_current_pc), 32'h0ABCD);
    chk("rtn_count", 32'(o_rstk_count), 32'h0);
    ph(3);
    chk("rtn_empty_pc",    32'(o_current_pc), 32'h0);
    chk("rtn_empty_count", 32'(o_rstk_count), 32'h0);
    i_rtn_instr = 1'b0;

    // Stall mid-decode: a stalled phase1/phase2 must not move PC or the nibble counter.
    i_jump_instr = 1'b1; i_jump_relative = 1'b0; i_jump_length = 3'd4;
    ph(3); ph(0); ph(1);
    chk("stall_pre_pc", 32'(o_current_pc), 32'h1);
    i_nibble = 4'h7;
    ph(2);
    i_stall = 1'b1; i_nibble = 4'h9;
    ph(1); ph(2); ph(1);
    chk("stall_pc",   32'(o_current_pc), 32'h1);
    chk("stall_busy", 32'(o_jump_busy),  32'h1);
    i_stall = 1'b0;
    ph(3); ph(0); ph(1);
    chk("unstall_pc", 32'(o_current_pc), 32'h2);
    rest = 16'hCBA8;
    i_nibble = rest[3:0];
    ph(2);
    for (int j = 1; j < 4; j++) begin
      ph(3); ph(0); ph(1);
      i_nibble = rest[4*j +: 4];
      ph(2);
    end
    i_jump_instr = 1'b0;
    chk("stall_target", 32'(o_current_pc), 32'hCBA87);
    chk("stall_done",   32'(o_jump_busy),  32'h0);

    // Asynchronous reset in the middle of a decode.
    i_rstk_push = 1'b1; i_rstk_push_val = 20'h00055;
    ph(0);
    i_rstk_push = 1'b0;
    chk("pre_rst_count", 32'(o_rstk_count), 32'h1);
    i_jump_instr = 1'b1;
    ph(3); ph(0); ph(1);
    i_nibble = 4'h5;
    ph(2);
    chk("pre_rst_busy", 32'(o_jump_busy), 32'h1);
    i_reset_n = 1'b0;
    #1;
    chk("mid_rst_pc",    32'(o_current_pc),   32'h0);
    chk("mid_rst_busy",  32'(o_jump_busy),    32'h0);
    chk("mid_rst_count", 32'(o_rstk_count),   32'h0);
    chk("mid_rst_pop",   32'(o_rstk_pop_val), 32'h0);
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1; i_jump_instr = 1'b0;
    ph(0); ph(1);
    chk("gate2_ph1", 32'(o_current_pc), 32'h0);
    ph(2); ph(3);

    // PC wrap and short relative offsets of both signs.
    jump(1'b0, 1'b0, 3'd4, 20'hFFFFF);
    chk("abs_fffff", 32'(o_current_pc), 32'hFFFFF);
    ph(0); ph(1);
    chk("pc_wrap", 32'(o_current_pc), 32'h0);
    jump(1'b1, 1'b0, 3'd1, 20'h00030);
    chk("rel2_pos", 32'(o_current_pc), 32'h00030);
    jump(1'b1, 1'b0, 3'd1, 20'h000F0);
    chk("rel2_neg", 32'(o_current_pc), 32'h00020);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
